// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the two-port i2c_master arbiter: state encoding, port indices,
// and timeout counter width.
package i2c_arb_pkg;

    localparam int unsigned CNT_W = 13;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StIssue = ST_ISSUE,
        StBusy  = ST_BUSY,
        StDone  = ST_DONE
    } arb_state_e;

endpackage

// File: rtl/i2c_rr_select.sv
// Two-input round-robin picker: a lone request wins outright, a tie goes to the port
// that was not served last.
module i2c_rr_select
    import i2c_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick
);

    always_comb begin
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = (last == PORT0) ? 2'b10 : 2'b01;
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/i2c_arbiter.sv
// Shares one i2c_master between two requesters: round-robin grant, latched transaction
// parameters, per-port handshake gating and completion/timeout reporting.
module i2c_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int unsigned START_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [6:0] addr0,
    input  logic [6:0] addr1,
    input  logic       rnw0,
    input  logic       rnw1,
    input  logic [2:0] size0,
    input  logic [2:0] size1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    input  logic       wvalid0,
    input  logic       wvalid1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       wreq0,
    output logic       wreq1,
    output logic       rvalid0,
    output logic       rvalid1,
    output logic [7:0] rdata,
    output logic       done0,
    output logic       done1,
    output logic       err0,
    output logic       err1,
    output logic       m_start,
    output logic [6:0] m_addr,
    output logic       m_read_nwrite,
    output logic [2:0] m_data_size,
    output logic [7:0] m_data_i,
    output logic       m_data_valid,
    input  logic       m_ready,
    input  logic       m_busy,
    input  logic       m_data_request,
    input  logic       m_data_available,
    input  logic [7:0] m_data_o
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(START_TIMEOUT - 1);

    arb_state_e       state;
    logic             last;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       pick;

    i2c_rr_select u_rr (
        .req  ({req1, req0}),
        .last (last),
        .pick (pick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= StIdle;
            last          <= PORT1;  // so a tie straight after reset goes to port 0
            cnt           <= '0;
            gnt0          <= 1'b0;
            gnt1          <= 1'b0;
            done0         <= 1'b0;
            done1         <= 1'b0;
            err0          <= 1'b0;
            err1          <= 1'b0;
            m_start       <= 1'b0;
            m_addr        <= '0;
            m_read_nwrite <= 1'b0;
            m_data_size   <= '0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            err0  <= 1'b0;
            err1  <= 1'b0;
            case (state)
                StIdle: begin
                    if ((req0 | req1) && m_ready && !m_busy) begin
                        gnt0          <= pick[0];
                        gnt1          <= pick[1];
                        m_addr        <= pick[1] ? addr1 : addr0;
                        m_read_nwrite <= pick[1] ? rnw1 : rnw0;
                        m_data_size   <= pick[1] ? size1 : size0;
                        m_start       <= 1'b1;
                        cnt           <= '0;
                        state         <= StIssue;
                    end
                end
                StIssue: begin
                    if (!m_ready) begin
                        m_start <= 1'b0;
                        state   <= StBusy;
                    end else if (cnt == TO_LAST) begin
                        m_start <= 1'b0;
                        done0   <= gnt0;
                        done1   <= gnt1;
                        err0    <= gnt0;
                        err1    <= gnt1;
                        state   <= StDone;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                StBusy: begin
                    if (m_ready) begin
                        done0 <= gnt0;
                        done1 <= gnt1;
                        state <= StDone;
                    end
                end
                StDone: begin
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    last  <= gnt1;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Byte handshakes reach only the port that owns the master.
    always_comb begin
        wreq0        = gnt0 & m_data_request;
        wreq1        = gnt1 & m_data_request;
        rvalid0      = gnt0 & m_data_available;
        rvalid1      = gnt1 & m_data_available;
        rdata        = m_data_o;
        m_data_valid = (gnt0 & wvalid0) | (gnt1 & wvalid1);
        m_data_i     = gnt0 ? wdata0 : (gnt1 ? wdata1 : 8'h00);
    end

endmodule
